// File: rtl/converter_f2fx.sv
// converter_f2fx: IEEE-754 single to signed Q(OUT_W-FRAC_W).FRAC_W fixed
// point with selectable rounding, sign-correct saturation and status flags.
module converter_f2fx #(
   parameter int OUT_W      = 32,
   parameter int FRAC_W     = 0,
   parameter int ROUND_MODE = 0
) (
   input  logic             i_CLK,
   input  logic             i_RST,
   input  logic [31:0]      i_A,
   input  logic             i_A_STB,
   output logic             o_A_ACK,
   output logic [OUT_W-1:0] o_Z,
   output logic             o_Z_STB,
   input  logic             i_Z_ACK,
   output logic             o_OVF,
   output logic             o_INEXACT,
   output logic             o_INV
);

   typedef enum logic [2:0] {
      S_GET, S_UNPACK, S_SHIFT, S_ROUND, S_PUT
   } state_t;

   typedef enum logic [1:0] {
      C_NORM, C_ZERO, C_INF, C_NAN
   } cls_t;

   // Smallest shift whose result can no longer fit in OUT_W bits.
   localparam logic signed [9:0] K_BIG = 10'(OUT_W - 23);

   state_t                 r_state;
   state_t                 w_next;
   logic [31:0]            r_a;
   logic                   r_s;
   cls_t                   r_cls;
   logic                   r_den;
   logic [23:0]            r_mant;
   logic signed [9:0]      r_k;
   logic [OUT_W-1:0]       r_mag;
   logic                   r_guard;
   logic                   r_sticky;
   logic                   r_big;

   logic [7:0]             w_e;
   logic [22:0]            w_m;
   cls_t                   w_cls;
   logic signed [9:0]      w_k;
   logic                   w_big;
   logic [OUT_W-1:0]       w_shl;
   logic [4:0]             w_n;
   logic [48:0]            w_shr;
   logic                   w_inc;
   logic [OUT_W:0]         w_r;
   logic                   w_povf;
   logic                   w_novf;
   logic                   w_ovf;
   logic [OUT_W-1:0]       w_maxp;
   logic [OUT_W-1:0]       w_maxn;
   logic [OUT_W-1:0]       w_sat;
   logic [OUT_W-1:0]       w_z;
   logic                   w_ovf_f;
   logic                   w_inx_f;
   logic                   w_inv_f;

   assign w_e = r_a[30:23];
   assign w_m = r_a[22:0];
   assign w_k = signed'(10'(w_e)) + signed'(10'(FRAC_W)) - 10'sd150;

   always_comb begin
      w_cls = C_NORM;
      if (w_e == 8'hFF)
         w_cls = (w_m != 23'd0) ? C_NAN : C_INF;
      else if (w_e == 8'h00)
         w_cls = C_ZERO;
   end

   assign w_big = (r_k >= K_BIG);
   assign w_shl = OUT_W'(r_mant) << r_k[5:0];
   assign w_n   = 5'(-r_k);
   assign w_shr = {r_mant, 25'd0} >> w_n;

   always_comb begin
      w_inc = 1'b0;
      if (ROUND_MODE == 1)
         w_inc = r_guard;
      else if (ROUND_MODE == 2)
         w_inc = r_guard & (r_sticky | r_mag[0]);
   end

   assign w_r    = {1'b0, r_mag} + {{OUT_W{1'b0}}, w_inc};
   assign w_povf = w_r[OUT_W] | w_r[OUT_W-1];
   assign w_novf = w_r[OUT_W] | (w_r[OUT_W-1] & (|w_r[OUT_W-2:0]));
   assign w_ovf  = r_big | (r_s ? w_novf : w_povf);
   assign w_maxp = {1'b0, {(OUT_W-1){1'b1}}};
   assign w_maxn = {1'b1, {(OUT_W-1){1'b0}}};
   assign w_sat  = r_s ? w_maxn : w_maxp;

   always_comb begin
      w_z     = '0;
      w_ovf_f = 1'b0;
      w_inx_f = 1'b0;
      w_inv_f = 1'b0;
      unique case (r_cls)
         C_NAN: w_inv_f = 1'b1;
         C_INF: begin
            w_z     = w_sat;
            w_ovf_f = 1'b1;
         end
         C_ZERO: w_inx_f = r_den;
         default: begin
            if (w_ovf) begin
               w_z     = w_sat;
               w_ovf_f = 1'b1;
               w_inx_f = 1'b1;
            end else begin
               w_z     = r_s ? -w_r[OUT_W-1:0] : w_r[OUT_W-1:0];
               w_inx_f = r_guard | r_sticky;
            end
         end
      endcase
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_GET:    if (o_A_ACK && i_A_STB) w_next = S_UNPACK;
         S_UNPACK: w_next = S_SHIFT;
         S_SHIFT:  w_next = S_ROUND;
         S_ROUND:  w_next = S_PUT;
         S_PUT:    if (o_Z_STB && i_Z_ACK) w_next = S_GET;
         default:  w_next = S_GET;
      endcase
   end

   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         r_state   <= S_GET;
         o_A_ACK   <= 1'b0;
         o_Z_STB   <= 1'b0;
         o_Z       <= '0;
         o_OVF     <= 1'b0;
         o_INEXACT <= 1'b0;
         o_INV     <= 1'b0;
         r_a       <= '0;
         r_s       <= 1'b0;
         r_cls     <= C_ZERO;
         r_den     <= 1'b0;
         r_mant    <= '0;
         r_k       <= '0;
         r_mag     <= '0;
         r_guard   <= 1'b0;
         r_sticky  <= 1'b0;
         r_big     <= 1'b0;
      end else begin
         r_state <= w_next;
         unique case (r_state)
            S_GET: begin
               if (o_A_ACK && i_A_STB) begin
                  r_a     <= i_A;
                  o_A_ACK <= 1'b0;
               end else begin
                  o_A_ACK <= 1'b1;
               end
            end
            S_UNPACK: begin
               r_s    <= r_a[31];
               r_cls  <= w_cls;
               r_den  <= (w_e == 8'h00) && (w_m != 23'd0);
               r_mant <= {1'b1, w_m};
               r_k    <= w_k;
            end
            S_SHIFT: begin
               r_mag    <= '0;
               r_guard  <= 1'b0;
               r_sticky <= 1'b0;
               r_big    <= 1'b0;
               if (w_big) begin
                  r_big <= 1'b1;
               end else if (!r_k[9]) begin
                  r_mag <= w_shl;
               end else if (r_k <= -10'sd26) begin
                  r_sticky <= 1'b1;
               end else begin
                  r_mag    <= OUT_W'(w_shr[48:25]);
                  r_guard  <= w_shr[24];
                  r_sticky <= |w_shr[23:0];
               end
            end
            S_ROUND: begin
               o_Z       <= w_z;
               o_OVF     <= w_ovf_f;
               o_INEXACT <= w_inx_f;
               o_INV     <= w_inv_f;
               o_Z_STB   <= 1'b1;
            end
            S_PUT: begin
               // Re-arm input acceptance on the same edge to reach 5-cycle throughput.
               if (o_Z_STB && i_Z_ACK) begin
                  o_Z_STB <= 1'b0;
                  o_A_ACK <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_converter_f2fx.sv
// tb_converter_f2fx: directed bench for converter_f2fx; three Q8.8 instances
// (one per rounding mode) and one default 32-bit instance share the inputs.
module tb_converter_f2fx;

   typedef struct packed {
      logic [31:0] a;
      logic [15:0] z0;
      logic [15:0] z1;
      logic [15:0] z2;
      logic [2:0]  f;
   } vec_t;

   logic        i_CLK = 1'b0;
   logic        i_RST = 1'b1;
   logic [31:0] i_A = '0;
   logic        i_A_STB = 1'b0;
   logic        i_Z_ACK = 1'b0;

   logic ack0, stb0, ovf0, inx0, inv0;
   logic ack1, stb1, ovf1, inx1, inv1;
   logic ack2, stb2, ovf2, inx2, inv2;
   logic ack3, stb3, ovf3, inx3, inv3;
   logic [15:0] z0, z1, z2;
   logic [31:0] z3;

   int n_chk = 0;
   int n_pass = 0;
   int lat = 0;

   converter_f2fx #(.OUT_W(16), .FRAC_W(8), .ROUND_MODE(0)) d0 (
      .i_CLK(i_CLK), .i_RST(i_RST), .i_A(i_A), .i_A_STB(i_A_STB),
      .o_A_ACK(ack0), .o_Z(z0), .o_Z_STB(stb0), .i_Z_ACK(i_Z_ACK),
      .o_OVF(ovf0), .o_INEXACT(inx0), .o_INV(inv0));

   converter_f2fx #(.OUT_W(16), .FRAC_W(8), .ROUND_MODE(1)) d1 (
      .i_CLK(i_CLK), .i_RST(i_RST), .i_A(i_A), .i_A_STB(i_A_STB),
      .o_A_ACK(ack1), .o_Z(z1), .o_Z_STB(stb1), .i_Z_ACK(i_Z_ACK),
      .o_OVF(ovf1), .o_INEXACT(inx1), .o_INV(inv1));

   converter_f2fx #(.OUT_W(16), .FRAC_W(8), .ROUND_MODE(2)) d2 (
      .i_CLK(i_CLK), .i_RST(i_RST), .i_A(i_A), .i_A_STB(i_A_STB),
      .o_A_ACK(ack2), .o_Z(z2), .o_Z_STB(stb2), .i_Z_ACK(i_Z_ACK),
      .o_OVF(ovf2), .o_INEXACT(inx2), .o_INV(inv2));

   converter_f2fx #(.OUT_W(32), .FRAC_W(0), .ROUND_MODE(0)) d3 (
      .i_CLK(i_CLK), .i_RST(i_RST), .i_A(i_A), .i_A_STB(i_A_STB),
      .o_A_ACK(ack3), .o_Z(z3), .o_Z_STB(stb3), .i_Z_ACK(i_Z_ACK),
      .o_OVF(ovf3), .o_INEXACT(inx3), .o_INV(inv3));

   always #5 i_CLK = ~i_CLK;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic run(input logic [31:0] a, input bit early);
      int n;
      i_A = a;
      i_A_STB = 1'b1;
      n = 0;
      while (!ack0 && n < 20) begin
         @(posedge i_CLK); #1;
         n++;
      end
      @(posedge i_CLK); #1;
      i_A_STB = 1'b0;
      lat = 0;
      while (!stb0 && lat < 12) begin
         i_Z_ACK = early && (lat < 2);
         @(posedge i_CLK); #1;
         lat++;
      end
      i_Z_ACK = 1'b0;
   endtask

   task automatic take();
      i_Z_ACK = 1'b1;
      @(posedge i_CLK); #1;
      i_Z_ACK = 1'b0;
   endtask

   task automatic test_reset();
      i_RST = 1'b1;
      i_A_STB = 1'b1;
      repeat (3) @(posedge i_CLK);
      #1;
      n_chk++;
      if ({ack0, stb0, z0, ovf0, inx0, inv0} !== '0)
         $display("FAIL reset_d0 got %h want 0",
                  {ack0, stb0, z0, ovf0, inx0, inv0});
      else n_pass++;
      n_chk++;
      if ({ack3, stb3, z3, ovf3, inx3, inv3} !== '0)
         $display("FAIL reset_d3 got %h want 0",
                  {ack3, stb3, z3, ovf3, inx3, inv3});
      else n_pass++;
      i_A_STB = 1'b0;
      i_RST = 1'b0;
      @(posedge i_CLK); #1;
      n_chk++;
      if ({ack0, stb0} !== 2'b10)
         $display("FAIL reset_ack got %b want 10", {ack0, stb0});
      else n_pass++;
   endtask

   task automatic test_exact();
      vec_t tv[4];
      tv = '{
         '{32'h3FC00000, 16'h0180, 16'h0180, 16'h0180, 3'b000},
         '{32'hC0300000, 16'hFD40, 16'hFD40, 16'hFD40, 3'b000},
         '{32'h00000000, 16'h0000, 16'h0000, 16'h0000, 3'b000},
         '{32'h80000000, 16'h0000, 16'h0000, 16'h0000, 3'b000}};
      for (int i = 0; i < 4; i++) begin
         run(tv[i].a, 1'b0);
         n_chk++;
         if ({z0, ovf0, inx0, inv0} !== {tv[i].z0, tv[i].f})
            $display("FAIL exact_m0 a=%h got %h want %h", tv[i].a,
                     {z0, ovf0, inx0, inv0}, {tv[i].z0, tv[i].f});
         else n_pass++;
         n_chk++;
         if ({z1, ovf1, inx1, inv1} !== {tv[i].z1, tv[i].f})
            $display("FAIL exact_m1 a=%h got %h want %h", tv[i].a,
                     {z1, ovf1, inx1, inv1}, {tv[i].z1, tv[i].f});
         else n_pass++;
         n_chk++;
         if ({z2, ovf2, inx2, inv2} !== {tv[i].z2, tv[i].f})
            $display("FAIL exact_m2 a=%h got %h want %h", tv[i].a,
                     {z2, ovf2, inx2, inv2}, {tv[i].z2, tv[i].f});
         else n_pass++;
         take();
      end
   endtask

   task automatic test_round();
      vec_t tv[4];
      tv = '{
         '{32'h3B000000, 16'h0000, 16'h0001, 16'h0000, 3'b010},
         '{32'h3BC00000, 16'h0001, 16'h0002, 16'h0002, 3'b010},
         '{32'hBB000000, 16'h0000, 16'hFFFF, 16'h0000, 3'b010},
         '{32'h3F800001, 16'h0100, 16'h0100, 16'h0100, 3'b010}};
      for (int i = 0; i < 4; i++) begin
         run(tv[i].a, 1'b0);
         n_chk++;
         if ({z0, ovf0, inx0, inv0} !== {tv[i].z0, tv[i].f})
            $display("FAIL round_m0 a=%h got %h want %h", tv[i].a,
                     {z0, ovf0, inx0, inv0}, {tv[i].z0, tv[i].f});
         else n_pass++;
         n_chk++;
         if ({z1, ovf1, inx1, inv1} !== {tv[i].z1, tv[i].f})
            $display("FAIL round_m1 a=%h got %h want %h", tv[i].a,
                     {z1, ovf1, inx1, inv1}, {tv[i].z1, tv[i].f});
         else n_pass++;
         n_chk++;
         if ({z2, ovf2, inx2, inv2} !== {tv[i].z2, tv[i].f})
            $display("FAIL round_m2 a=%h got %h want %h", tv[i].a,
                     {z2, ovf2, inx2, inv2}, {tv[i].z2, tv[i].f});
         else n_pass++;
         take();
      end
   endtask

   task automatic test_saturation();
      vec_t tv[6];
      tv = '{
         '{32'h43480000, 16'h7FFF, 16'h7FFF, 16'h7FFF, 3'b110},
         '{32'hC3000000, 16'h8000, 16'h8000, 16'h8000, 3'b000},
         '{32'hC3480000, 16'h8000, 16'h8000, 16'h8000, 3'b110},
         '{32'hFF800000, 16'h8000, 16'h8000, 16'h8000, 3'b100},
         '{32'h7FC00000, 16'h0000, 16'h0000, 16'h0000, 3'b001},
         '{32'h00000001, 16'h0000, 16'h0000, 16'h0000, 3'b010}};
      for (int i = 0; i < 6; i++) begin
         run(tv[i].a, 1'b0);
         n_chk++;
         if ({z0, ovf0, inx0, inv0} !== {tv[i].z0, tv[i].f})
            $display("FAIL sat_m0 a=%h got %h want %h", tv[i].a,
                     {z0, ovf0, inx0, inv0}, {tv[i].z0, tv[i].f});
         else n_pass++;
         n_chk++;
         if ({z1, ovf1, inx1, inv1} !== {tv[i].z1, tv[i].f})
            $display("FAIL sat_m1 a=%h got %h want %h", tv[i].a,
                     {z1, ovf1, inx1, inv1}, {tv[i].z1, tv[i].f});
         else n_pass++;
         n_chk++;
         if ({z2, ovf2, inx2, inv2} !== {tv[i].z2, tv[i].f})
            $display("FAIL sat_m2 a=%h got %h want %h", tv[i].a,
                     {z2, ovf2, inx2, inv2}, {tv[i].z2, tv[i].f});
         else n_pass++;
         take();
      end
   endtask

   task automatic test_defaults();
      logic [31:0] av[3];
      logic [34:0] ev[3];
      av = '{32'h4B000001, 32'hCF000000, 32'h4F000000};
      ev = '{{32'h00800001, 3'b000},
             {32'h80000000, 3'b000},
             {32'h7FFFFFFF, 3'b110}};
      for (int i = 0; i < 3; i++) begin
         run(av[i], 1'b0);
         n_chk++;
         if ({z3, ovf3, inx3, inv3} !== ev[i])
            $display("FAIL defaults a=%h got %h want %h", av[i],
                     {z3, ovf3, inx3, inv3}, ev[i]);
         else n_pass++;
         take();
      end
   endtask

   task automatic test_handshake();
      run(32'h3FC00000, 1'b1);
      n_chk++;
      if (lat !== 3)
         $display("FAIL latency got %0d want 3", lat);
      else n_pass++;
      for (int i = 0; i < 6; i++) begin
         @(posedge i_CLK); #1;
         n_chk++;
         if ({stb0, z0, ovf0, inx0, inv0} !== {1'b1, 16'h0180, 3'b000})
            $display("FAIL hold[%0d] got %h want %h", i,
                     {stb0, z0, ovf0, inx0, inv0},
                     {1'b1, 16'h0180, 3'b000});
         else n_pass++;
      end
      take();
      n_chk++;
      if (stb0 !== 1'b0)
         $display("FAIL release got %b want 0", stb0);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] av[3];
      logic [15:0] ez[3];
      int got;
      int idx;
      int last;
      av = '{32'h3FC00000, 32'hC0300000, 32'h43480000};
      ez = '{16'h0180, 16'hFD40, 16'h7FFF};
      got = 0;
      idx = 0;
      last = 0;
      i_Z_ACK = 1'b1;
      for (int c = 0; c < 60 && got < 3; c++) begin
         if (ack0) begin
            i_A_STB = (idx < 3);
            if (idx < 3) begin
               i_A = av[idx];
               idx++;
            end
         end
         @(posedge i_CLK); #1;
         if (stb0) begin
            n_chk++;
            if (z0 !== ez[got])
               $display("FAIL b2b_val[%0d] got %h want %h", got, z0, ez[got]);
            else n_pass++;
            if (got > 0) begin
               n_chk++;
               if (c - last !== 5)
                  $display("FAIL b2b_gap[%0d] got %0d want 5", got, c - last);
               else n_pass++;
            end
            last = c;
            got++;
         end
      end
      @(posedge i_CLK); #1;
      i_Z_ACK = 1'b0;
      i_A_STB = 1'b0;
      n_chk++;
      if (got !== 3)
         $display("FAIL b2b_count got %0d want 3", got);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      int n;
      bit seen;
      i_A = 32'hC3480000;
      i_A_STB = 1'b1;
      n = 0;
      while (!ack0 && n < 20) begin
         @(posedge i_CLK); #1;
         n++;
      end
      @(posedge i_CLK); #1;
      i_A_STB = 1'b0;
      @(posedge i_CLK); #1;
      i_RST = 1'b1;
      @(posedge i_CLK); #1;
      n_chk++;
      if ({ack0, stb0, z0, ovf0, inx0, inv0} !== '0)
         $display("FAIL rstmid_d0 got %h want 0",
                  {ack0, stb0, z0, ovf0, inx0, inv0});
      else n_pass++;
      n_chk++;
      if ({ack3, stb3, z3, ovf3, inx3, inv3} !== '0)
         $display("FAIL rstmid_d3 got %h want 0",
                  {ack3, stb3, z3, ovf3, inx3, inv3});
      else n_pass++;
      i_RST = 1'b0;
      @(posedge i_CLK); #1;
      n_chk++;
      if ({ack0, stb0} !== 2'b10)
         $display("FAIL rstmid_ack got %b want 10", {ack0, stb0});
      else n_pass++;
      seen = 1'b0;
      repeat (5) begin
         @(posedge i_CLK); #1;
         if (stb0) seen = 1'b1;
      end
      n_chk++;
      if (seen !== 1'b0)
         $display("FAIL rstmid_stale got %b want 0", seen);
      else n_pass++;
      run(32'hC0300000, 1'b0);
      n_chk++;
      if ({z0, ovf0, inx0, inv0} !== {16'hFD40, 3'b000})
         $display("FAIL rstmid_next got %h want %h",
                  {z0, ovf0, inx0, inv0}, {16'hFD40, 3'b000});
      else n_pass++;
      take();
   endtask

   initial begin
      test_reset();
      test_exact();
      test_round();
      test_saturation();
      test_defaults();
      test_handshake();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
